// File: rtl/vga_fb_scanout.sv
// VGA scan-out: sync/blank timing, framebuffer word fetch,
// RGB332/RGB565 unpack with integer upscaling and 8-bit colour expansion.
module vga_fb_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIX_DIV  = 2,
    parameter int VGA_BITS = 8,
    parameter int SCALE    = 16,
    parameter int FB_W     = 40,
    parameter int FB_H     = 30,
    parameter int ADDR_W   = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] fb_base,
    output logic [ADDR_W-1:0] addr_vga,
    input  logic [31:0]       read_data_vga,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic              frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;
    localparam int PPW     = 32 / VGA_BITS;
    localparam int ROW_W   = FB_W / PPW;
    localparam int LW      = $clog2(PPW);
    localparam int DW      = $clog2(PIX_DIV > 1 ? PIX_DIV : 2);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int SW      = $clog2(SCALE > 1 ? SCALE : 2);
    localparam int FXW     = $clog2(FB_W + 1);
    localparam int FYW     = $clog2(FB_H + 1);

    logic [DW-1:0]     div_q;
    logic [HW-1:0]     h_q;
    logic [VW-1:0]     v_q;
    logic [SW-1:0]     sx_q, sy_q;
    logic [FXW-1:0]    fx_q;
    logic [FYW-1:0]    fy_q;
    logic [ADDR_W-1:0] row_q, base_q, addr_q;
    logic [LW-1:0]     lane_q;
    logic              vis_q, hs1_q, vs1_q, first_q;
    logic [7:0]        r_q, g_q, b_q;
    logic              de_q, hs_q, vs_q, fs_q;

    logic              pe, div_last, h_last, v_last;
    logic              h_vis, v_vis, vis, at_origin, hs_d, vs_d;
    logic [ADDR_W-1:0] base_d, addr_d;
    logic [15:0]       pix;
    logic [7:0]        r_d, g_d, b_d;

    always_comb begin
        pe        = div_q == '0;
        div_last  = div_q == DW'(PIX_DIV - 1);
        h_last    = h_q == HW'(H_TOTAL - 1);
        v_last    = v_q == VW'(V_TOTAL - 1);
        h_vis     = h_q < HW'(H_ACTIVE);
        v_vis     = v_q < VW'(V_ACTIVE);
        vis       = h_vis && v_vis;
        at_origin = (h_q == '0) && (v_q == '0);
        hs_d      = !((h_q >= HW'(HS_BEG)) && (h_q < HW'(HS_END)));
        vs_d      = !((v_q >= VW'(VS_BEG)) && (v_q < VW'(VS_END)));
        // The new frame's base is used for its very first fetch.
        base_d    = at_origin ? fb_base : base_q;
        addr_d    = base_d + row_q + ADDR_W'(fx_q >> LW);
        pix       = 16'(read_data_vga >> (32'(lane_q) << $clog2(VGA_BITS)));
        if (VGA_BITS == 8) begin
            r_d = {pix[7:5], pix[7:5], pix[7:6]};
            g_d = {pix[4:2], pix[4:2], pix[4:3]};
            b_d = {4{pix[1:0]}};
        end else begin
            r_d = {pix[15:11], pix[15:13]};
            g_d = {pix[10:5], pix[10:9]};
            b_d = {pix[4:0], pix[4:2]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
            row_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            lane_q  <= '0;
            vis_q   <= 1'b0;
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            first_q <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            de_q    <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            div_q <= div_last ? '0 : div_q + 1'b1;
            if (pe) begin
                if (h_last) begin
                    h_q  <= '0;
                    sx_q <= '0;
                    fx_q <= '0;
                    if (v_last) begin
                        v_q   <= '0;
                        sy_q  <= '0;
                        fy_q  <= '0;
                        row_q <= '0;
                    end else begin
                        v_q <= v_q + 1'b1;
                        if (v_vis) begin
                            if (sy_q == SW'(SCALE - 1)) begin
                                sy_q <= '0;
                                // Past the last row no visible line remains.
                                if (fy_q != FYW'(FB_H - 1)) begin
                                    fy_q  <= fy_q + 1'b1;
                                    row_q <= row_q + ADDR_W'(ROW_W);
                                end
                            end else begin
                                sy_q <= sy_q + 1'b1;
                            end
                        end
                    end
                end else begin
                    h_q <= h_q + 1'b1;
                    if (h_vis) begin
                        if (sx_q == SW'(SCALE - 1)) begin
                            sx_q <= '0;
                            fx_q <= fx_q + 1'b1;
                        end else begin
                            sx_q <= sx_q + 1'b1;
                        end
                    end
                end
                if (at_origin) base_q <= fb_base;
                if (vis) addr_q <= addr_d;
                lane_q  <= fx_q[LW-1:0];
                vis_q   <= vis;
                hs1_q   <= hs_d;
                vs1_q   <= vs_d;
                first_q <= at_origin;
                de_q    <= vis_q;
                r_q     <= vis_q ? r_d : '0;
                g_q     <= vis_q ? g_d : '0;
                b_q     <= vis_q ? b_d : '0;
                hs_q    <= hs1_q;
                vs_q    <= vs1_q;
            end
            fs_q <= pe & first_q;
        end
    end

    assign addr_vga    = addr_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_de      = de_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench for vga_fb_scanout on a reduced 40x12 raster,
// one RGB332 and one RGB565 instance sharing clock and reset.
module tb_vga_fb_scanout;
    localparam int NPOS = 960;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  fb8 = 4'd0;
    logic [3:0]  fb16 = 4'd0;
    logic [3:0]  a8, a16;
    logic [31:0] rd8, rd16;
    logic [7:0]  r8, g8, b8, r16, g16, b16;
    logic        hs8, vs8, de8, fs8;
    logic        hs16, vs16, de16, fs16;

    logic [31:0] mem8 [16];
    logic [31:0] mem16 [16];

    logic [23:0] rgb8_a [NPOS];
    logic [23:0] rgb16_a [NPOS];
    logic        de8_a [NPOS];
    logic        hs8_a [NPOS];
    logic        vs8_a [NPOS];
    logic        fs8_a [NPOS];
    logic [3:0]  adr8_a [NPOS];
    logic [3:0]  adr16_a [NPOS];

    int n_chk = 0;
    int n_fail = 0;
    int hs_fall = 0;
    int fs_e0 = 0;
    int fs_e1 = 0;
    logic mid_fs = 1'b1;

    always #5 clk = ~clk;

    assign rd8  = mem8[a8];
    assign rd16 = mem16[a16];

    vga_fb_scanout #(
        .H_ACTIVE(32), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIX_DIV(2), .VGA_BITS(8), .SCALE(4),
        .FB_W(8), .FB_H(2), .ADDR_W(4)
    ) u_dut8 (
        .clk(clk), .reset(reset), .fb_base(fb8),
        .addr_vga(a8), .read_data_vga(rd8),
        .vga_r(r8), .vga_g(g8), .vga_b(b8),
        .vga_hs(hs8), .vga_vs(vs8), .vga_de(de8),
        .frame_start(fs8)
    );

    vga_fb_scanout #(
        .H_ACTIVE(32), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIX_DIV(2), .VGA_BITS(16), .SCALE(4),
        .FB_W(8), .FB_H(2), .ADDR_W(4)
    ) u_dut16 (
        .clk(clk), .reset(reset), .fb_base(fb16),
        .addr_vga(a16), .read_data_vga(rd16),
        .vga_r(r16), .vga_g(g16), .vga_b(b16),
        .vga_hs(hs16), .vga_vs(vs16), .vga_de(de16),
        .frame_start(fs16)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hs"}, 32'(hs8), 32'd1);
        chk({tag, "_vs"}, 32'(vs8), 32'd1);
        chk({tag, "_de"}, 32'(de8), 32'd0);
        chk({tag, "_rgb"}, 32'({r8, g8, b8}), 32'h0);
        chk({tag, "_addr"}, 32'(a8), 32'd0);
        chk({tag, "_fs"}, 32'(fs8), 32'd0);
        chk({tag, "_rgb16"}, 32'({r16, g16, b16}), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem8[i]  = 32'h0;
            mem16[i] = 32'h0;
        end
        mem8[0]  = 32'h00E31CFF;
        mem8[1]  = 32'h0000006D;
        mem8[2]  = 32'h000000E0;
        mem8[3]  = 32'hFFFFFFFF;
        mem8[14] = 32'h000000FF;
        mem16[0] = 32'hF80007E0;
        mem16[1] = 32'h0000001F;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");

        @(negedge clk);
        reset = 1'b1;
        for (int n = 1; n <= NPOS + 2; n++) begin
            if (n > 1) begin
                @(posedge clk);
                #1;
                if (n == 3) mid_fs = fs8;
            end
            @(posedge clk);
            #1;
            if (n >= 2 && n - 2 < NPOS) begin
                rgb8_a[n-2]  = {r8, g8, b8};
                rgb16_a[n-2] = {r16, g16, b16};
                de8_a[n-2]   = de8;
                hs8_a[n-2]   = hs8;
                vs8_a[n-2]   = vs8;
                fs8_a[n-2]   = fs8;
            end
            if (n - 1 < NPOS) begin
                adr8_a[n-1]  = a8;
                adr16_a[n-1] = a16;
            end
            if (!hs8 && hs_fall == 0) hs_fall = 2 * n - 1;
            if (fs8) begin
                if (fs_e0 == 0) fs_e0 = 2 * n - 1;
                else if (fs_e1 == 0) fs_e1 = 2 * n - 1;
            end
            if (n == 100) fb8 = 4'd14;
        end

        chk("px0_white",   32'(rgb8_a[0]),   32'hFFFFFF);
        chk("px0_de",      32'(de8_a[0]),    32'd1);
        chk("px5_green",   32'(rgb8_a[5]),   32'h00FF00);
        chk("px8_e3",      32'(rgb8_a[8]),   32'hFF00FF);
        chk("px15_black",  32'(rgb8_a[15]),  32'h000000);
        chk("px15_de",     32'(de8_a[15]),   32'd1);
        chk("px16_6d",     32'(rgb8_a[16]),  32'h6D6D55);
        chk("px31_de",     32'(de8_a[31]),   32'd1);
        chk("hblank_de",   32'(de8_a[32]),   32'd0);
        chk("hblank_rgb",  32'(rgb8_a[32]),  32'h0);
        chk("row1_red",    32'(rgb8_a[160]), 32'hFF0000);
        chk("vblank_de",   32'(de8_a[320]),  32'd0);
        chk("vblank_rgb",  32'(rgb8_a[320]), 32'h0);
        chk("hs_pre",      32'(hs8_a[33]),   32'd1);
        chk("hs_lo0",      32'(hs8_a[34]),   32'd0);
        chk("hs_lo2",      32'(hs8_a[36]),   32'd0);
        chk("hs_post",     32'(hs8_a[37]),   32'd1);
        chk("hs_fall_clk", 32'(hs_fall),     32'd71);
        chk("vs_pre",      32'(vs8_a[359]),  32'd1);
        chk("vs_lo0",      32'(vs8_a[360]),  32'd0);
        chk("vs_lo1",      32'(vs8_a[439]),  32'd0);
        chk("vs_post",     32'(vs8_a[440]),  32'd1);
        chk("fs_px0",      32'(fs8_a[0]),    32'd1);
        chk("fs_mid",      32'(mid_fs),      32'd0);
        chk("fs_px1",      32'(fs8_a[1]),    32'd0);
        chk("fs_first",    32'(fs_e0),       32'd3);
        chk("fs_period",   32'(fs_e1 - fs_e0), 32'd960);
        chk("adr_0",       32'(adr8_a[0]),   32'd0);
        chk("adr_16",      32'(adr8_a[16]),  32'd1);
        chk("adr_hold",    32'(adr8_a[33]),  32'd1);
        chk("adr_line1",   32'(adr8_a[40]),  32'd0);
        chk("adr_row1",    32'(adr8_a[160]), 32'd2);
        chk("adr_last",    32'(adr8_a[311]), 32'd3);
        chk("f1_adr_0",    32'(adr8_a[480]), 32'd14);
        chk("f1_adr_16",   32'(adr8_a[496]), 32'd15);
        chk("f1_adr_wrap", 32'(adr8_a[640]), 32'd0);
        chk("f1_adr_wr1",  32'(adr8_a[656]), 32'd1);
        chk("f1_px0",      32'(rgb8_a[480]), 32'hFFFFFF);
        chk("p16_px0",     32'(rgb16_a[0]),  32'h00FF00);
        chk("p16_px4",     32'(rgb16_a[4]),  32'hFF0000);
        chk("p16_px8",     32'(rgb16_a[8]),  32'h0000FF);
        chk("p16_adr_0",   32'(adr16_a[0]),  32'd0);
        chk("p16_adr_8",   32'(adr16_a[8]),  32'd1);
        chk("p16_adr_31",  32'(adr16_a[31]), 32'd3);
        chk("p16_adr_row", 32'(adr16_a[160]), 32'd4);

        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            @(posedge clk);
        end
        #1;
        chk("pre_rst_de", 32'(de8), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_adr", 32'(a8), 32'd14);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("restart_px0", 32'({r8, g8, b8}), 32'hFFFFFF);
        chk("restart_fs",  32'(fs8), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
